// File: rtl/pingpong_blockbuf_if.sv
// Producer/consumer bundle for pingpong_blockbuf. The consumer's release strobe is
// named release_blk because "release" is a reserved SystemVerilog keyword.
interface pingpong_blockbuf_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              write;
    logic [WIDTH-1:0]  data_i;
    logic              ready;
    logic              blk_valid;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_ptr;
    logic [WIDTH-1:0]  data_o;
    logic              release_blk;

    modport master (
        output write, data_i, rd_ptr, release_blk,
        input  ready, blk_valid, rd_bank, data_o
    );

    modport slave (
        input  write, data_i, rd_ptr, release_blk,
        output ready, blk_valid, rd_bank, data_o
    );
endinterface

// File: rtl/pingpong_blockbuf.sv
// Two-bank block buffer: producer fills one bank while the consumer reads the other.
// Optional refused-write counter enabled by defining BLOCKBUF_DROP_CNT_EN.
module pingpong_blockbuf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    pingpong_blockbuf_if.slave  bus
`ifdef BLOCKBUF_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic {FREE = 1'b0, FULL = 1'b1} bank_state_t;

    bank_state_t      bank_st [2];
    logic             wbank;
    logic             rbank;
    logic [ADDR_W:0]  wcnt;
    logic [WIDTH-1:0] mem [2][DEPTH];

    logic accept;
    logic rel_ok;

    assign bus.ready     = (bank_st[wbank] == FREE);
    assign bus.blk_valid = (bank_st[rbank] == FULL);
    assign bus.rd_bank   = rbank;
    assign accept        = bus.write & bus.ready;
    assign rel_ok        = bus.release_blk & bus.blk_valid;

    // A release and a write can never target the same bank: one needs FULL, the other FREE.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_st[0] <= FREE;
            bank_st[1] <= FREE;
            wbank      <= 1'b0;
            rbank      <= 1'b0;
            wcnt       <= '0;
        end else begin
            if (rel_ok) begin
                bank_st[rbank] <= FREE;
                rbank          <= ~rbank;
            end
            if (accept) begin
                if (wcnt == LAST) begin
                    bank_st[wbank] <= FULL;
                    wbank          <= ~wbank;
                    wcnt           <= '0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

    // Storage is deliberately not reset; stale words are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wbank][wcnt[ADDR_W-1:0]] <= bus.data_i;
        end
    end

    always_comb begin
        bus.data_o = '0;
        if (bus.blk_valid && ({1'b0, bus.rd_ptr} < DEPTH_L)) begin
            bus.data_o = mem[rbank][bus.rd_ptr];
        end
    end

`ifdef BLOCKBUF_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (bus.write && !bus.ready && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_blockbuf.sv
// Bench for pingpong_blockbuf: vector table for the fill/overflow/release sequence,
// hand-written corner sequences, and a scoreboarded random stream.
module tb_pingpong_blockbuf;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pingpong_blockbuf_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef BLOCKBUF_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    pingpong_blockbuf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef BLOCKBUF_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference state of the buffer
    bit       m_full [2];
    bit       m_wbank, m_rbank;
    int       m_wcnt;
    int       m_drop;
    bit       sb_on;
    logic [WIDTH-1:0] exp_q [$];

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] d;
        logic             rel;
        logic [ADDR_W-1:0] ptr;
        logic             e_ready;
        logic             e_bv;
        logic             e_rb;
        logic [WIDTH-1:0] e_do;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full[0] = 0; m_full[1] = 0;
        m_wbank = 0; m_rbank = 0; m_wcnt = 0; m_drop = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic rel,
                         input logic [ADDR_W-1:0] ptr);
        @(negedge clk);
        bus.write = w;
        bus.data_i = d;
        bus.release_blk = rel;
        bus.rd_ptr = ptr;
        #1;
    endtask

    // Advance the reference with the inputs currently driven (applied at the coming edge).
    task automatic commit();
        bit acc, relv;
        acc  = bus.write && !m_full[m_wbank];
        relv = bus.release_blk && m_full[m_rbank];
        if (bus.write && m_full[m_wbank] && m_drop < 16'hFFFF) m_drop++;
        if (relv) begin
            m_full[m_rbank] = 0;
            m_rbank = ~m_rbank;
        end
        if (acc) begin
            if (sb_on) exp_q.push_back(bus.data_i);
            if (m_wcnt == DEPTH - 1) begin
                m_full[m_wbank] = 1;
                m_wbank = ~m_wbank;
                m_wcnt = 0;
            end else begin
                m_wcnt++;
            end
        end
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, ".ready"}, 32'(bus.ready), 32'(!m_full[m_wbank]));
        chk({tag, ".blk_valid"}, 32'(bus.blk_valid), 32'(m_full[m_rbank]));
        chk({tag, ".rd_bank"}, 32'(bus.rd_bank), 32'(m_rbank));
        if (!m_full[m_rbank]) chk({tag, ".data_o_idle"}, 32'(bus.data_o), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.write = 1'b0;
        bus.release_blk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic read_block(input string tag);
        logic [WIDTH-1:0] e;
        for (int p = 0; p < DEPTH; p++) begin
            drive(1'b0, '0, 1'b0, ADDR_W'(p));
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".data_o"}, 32'(bus.data_o), 32'(e));
            end
            commit();
        end
    endtask

    initial begin
        bus.write = 1'b0;
        bus.data_i = '0;
        bus.release_blk = 1'b0;
        bus.rd_ptr = '0;
        sb_on = 0;
        model_reset();

        // Vector table: words 0x10.. into bank 0, 0x20.. into bank 1, overflow, release.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, WIDTH'(8'h10 + i), 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8] = '{1'b1, 8'h20, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 8'h13};
        for (int i = 9; i < 16; i++)
            vecs[i] = '{1'b1, WIDTH'(8'h20 + i - 8), 1'b0, ADDR_W'(i - 8), 1'b1, 1'b1, 1'b0,
                        WIDTH'(8'h10 + i - 8)};
        vecs[16] = '{1'b1, 8'h99, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h10};
        vecs[17] = '{1'b1, 8'h98, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 8'h17};
        vecs[18] = '{1'b1, 8'h30, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 8'h27};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 8'h20};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        bus.rd_ptr = 3'd3;
        #1;
        chk("rst.ready", 32'(bus.ready), 32'd1);
        chk("rst.blk_valid", 32'(bus.blk_valid), 32'd0);
        chk("rst.rd_bank", 32'(bus.rd_bank), 32'd0);
        chk("rst.data_o", 32'(bus.data_o), 32'd0);
`ifdef BLOCKBUF_DROP_CNT_EN
        chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].wr, vecs[i].d, vecs[i].rel, vecs[i].ptr);
            chk($sformatf("vec%0d.ready", i), 32'(bus.ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d.blk_valid", i), 32'(bus.blk_valid), 32'(vecs[i].e_bv));
            chk($sformatf("vec%0d.rd_bank", i), 32'(bus.rd_bank), 32'(vecs[i].e_rb));
            chk($sformatf("vec%0d.data_o", i), 32'(bus.data_o), 32'(vecs[i].e_do));
`ifdef BLOCKBUF_DROP_CNT_EN
            if (i == 17) chk("vec17.drop_cnt", 32'(drop_cnt), 32'd1);
            if (i == 18) chk("vec18.drop_cnt", 32'(drop_cnt), 32'd2);
`endif
            commit();
        end

        // Reset after a partial block: partial data discarded, full blocks dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, WIDTH'(8'h50 + i), 1'b0, 3'd0);
            commit();
        end
        do_reset();
        bus.write = 1'b0;
        bus.rd_ptr = 3'd0;
        #1;
        chk("mid_rst.ready", 32'(bus.ready), 32'd1);
        chk("mid_rst.blk_valid", 32'(bus.blk_valid), 32'd0);
        chk("mid_rst.data_o", 32'(bus.data_o), 32'd0);

        // Next 8 writes form block 0 from word 0
        sb_on = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, WIDTH'(8'h60 + i), 1'b0, 3'd0);
            check_ctrl("blk60");
            commit();
        end
        read_block("blk60");

        // Final write of bank 1 together with release of bank 0
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, WIDTH'(8'h70 + i), 1'b0, 3'd0);
            commit();
        end
        drive(1'b1, 8'h77, 1'b1, 3'd0);
        check_ctrl("simul.pre");
        commit();
        drive(1'b0, '0, 1'b0, 3'd7);
        chk("simul.blk_valid", 32'(bus.blk_valid), 32'd1);
        chk("simul.rd_bank", 32'(bus.rd_bank), 32'd1);
        chk("simul.ready", 32'(bus.ready), 32'd1);
        commit();
        read_block("blk70");

        // Release bank 1, then a release with nothing valid must be ignored
        drive(1'b0, '0, 1'b1, 3'd0);
        commit();
        drive(1'b0, '0, 1'b1, 3'd0);
        chk("idle_rel.pre_blk_valid", 32'(bus.blk_valid), 32'd0);
        commit();
        drive(1'b0, '0, 1'b0, 3'd0);
        chk("idle_rel.rd_bank", 32'(bus.rd_bank), 32'd0);
        chk("idle_rel.ready", 32'(bus.ready), 32'd1);
        chk("idle_rel.blk_valid", 32'(bus.blk_valid), 32'd0);
        chk("idle_rel.data_o", 32'(bus.data_o), 32'd0);
        commit();

        // Random stream with consumer reading and releasing at random
        for (int it = 0; it < 300; it++) begin
            drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'b0,
                  ADDR_W'($urandom_range(0, DEPTH - 1)));
            check_ctrl("rand");
            commit();
            if (m_full[m_rbank] && $urandom_range(0, 2) == 0) begin
                read_block("rand");
                drive(1'b0, '0, 1'b1, 3'd0);
                commit();
            end
        end
        drive(1'b0, '0, 1'b0, 3'd0);
        check_ctrl("rand.end");
`ifdef BLOCKBUF_DROP_CNT_EN
        chk("rand.drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
